match_sequencer: RTL

Match-level state machine for the Pong game. It sits above the ball/paddle game core and gates ball motion with `game_run`. It recentres the ball through `ball_reset` before every serve and counts goals reported by the core. It declares a winner at `WIN_SCORE` and restarts the match on a start-button press.

---
 rtl/match_sequencer_if.sv | 53 +++++
 rtl/match_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/match_sequencer_if.sv
// rtl/match_sequencer_if.sv - signal bundle between the Pong game core and the match sequencer
//
// Purpose: carries the player controls, the goal pulses and the match status
//          between the Pong core and match_sequencer.
// Parameter: WIN_SCORE sets the score width. It must match the sequencer's WIN_SCORE.
// Signals:
//   start_btn            raw start button, asynchronous to clk
//   pause_btn            raw pause button, asynchronous to clk
//                        (present only with MATCH_SEQUENCER_PAUSE_EN)
//   goal_1 / goal_2      one-cycle goal pulses from the game core
//   game_run             game core may advance ball and paddles
//   ball_reset           one-cycle recentre pulse to the game core
//   serve_dir            0 = serve left (player 1), 1 = serve right (player 2)
//   score_1 / score_2    player scores
//   winner               00 none, 01 player 1, 10 player 2
// Modports: master = core/board side, slave = sequencer side.
// Macro: MATCH_SEQUENCER_PAUSE_EN adds pause_btn.
interface match_sequencer_if #(
  parameter int WIN_SCORE = 5
) ();
  localparam int SCORE_W = $clog2(WIN_SCORE + 1);

  logic               start_btn;
  logic               goal_1;
  logic               goal_2;
  logic               game_run;
  logic               ball_reset;
  logic               serve_dir;
  logic [SCORE_W-1:0] score_1;
  logic [SCORE_W-1:0] score_2;
  logic [1:0]         winner;
`ifdef MATCH_SEQUENCER_PAUSE_EN
  logic               pause_btn;

  modport master (
    output start_btn, pause_btn, goal_1, goal_2,
    input  game_run, ball_reset, serve_dir, score_1, score_2, winner
  );
  modport slave (
    input  start_btn, pause_btn, goal_1, goal_2,
    output game_run, ball_reset, serve_dir, score_1, score_2, winner
  );
`else
  modport master (
    output start_btn, goal_1, goal_2,
    input  game_run, ball_reset, serve_dir, score_1, score_2, winner
  );
  modport slave (
    input  start_btn, goal_1, goal_2,
    output game_run, ball_reset, serve_dir, score_1, score_2, winner
  );
`endif
endinterface

// File: rtl/match_sequencer.sv
// rtl/match_sequencer.sv - Pong match-level state machine (serve, play, score, winner)
//
// Purpose: gates the game core with game_run and recentres the ball before
//          every serve. It also counts goals and declares a winner at WIN_SCORE.
//          A start press begins or restarts a match.
// Parameters:
//   WIN_SCORE              points needed to win (>= 1)
//   SERVE_DELAY_IN_CLOCKS  SERVE hold length in cycles (>= 1)
// Ports:
//   clk   system clock
//   rst   asynchronous, active-low reset
//   bus   match_sequencer_if.slave:
//         inputs  start_btn, goal_1, goal_2 (and pause_btn)
//         outputs game_run, ball_reset, serve_dir, score_1, score_2, winner
// Macro: MATCH_SEQUENCER_PAUSE_EN adds pause_btn and a PAUSED state.
//        A pause press in PLAY freezes the game. A second press resumes it
//        without a new serve.
module match_sequencer #(
  parameter int WIN_SCORE             = 5,
  parameter int SERVE_DELAY_IN_CLOCKS = 50_000_000
) (
  input  logic                clk,
  input  logic                rst,
  match_sequencer_if.slave    bus
);
  localparam int SCORE_W = $clog2(WIN_SCORE + 1);
  localparam int CNT_W   = $clog2(SERVE_DELAY_IN_CLOCKS + 1);
  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_DELAY_IN_CLOCKS - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SERVE,
    S_PLAY,
`ifdef MATCH_SEQUENCER_PAUSE_EN
    S_PAUSED,
`endif
    S_GAME_OVER
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   serve_cnt;
  logic               game_run_q;
  logic               ball_reset_q;
  logic               serve_dir_q;
  logic [SCORE_W-1:0] score_1_q;
  logic [SCORE_W-1:0] score_2_q;
  logic [1:0]         winner_q;

  // [0],[1] form the synchronizer. [2] holds the previous synchronized level.
  // The rising-edge pulse is registered once more before the FSM sees it, so
  // a press acts three edges after the edge that first samples it.
  logic [2:0] start_sync;
  logic       start_pulse_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_sync    <= '0;
      start_pulse_q <= 1'b0;
    end else begin
      start_sync    <= {start_sync[1:0], bus.start_btn};
      start_pulse_q <= start_sync[1] & ~start_sync[2];
    end
  end

`ifdef MATCH_SEQUENCER_PAUSE_EN
  logic [2:0] pause_sync;
  logic       pause_pulse_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pause_sync    <= '0;
      pause_pulse_q <= 1'b0;
    end else begin
      pause_sync    <= {pause_sync[1:0], bus.pause_btn};
      pause_pulse_q <= pause_sync[1] & ~pause_sync[2];
    end
  end
`endif

  logic [SCORE_W-1:0] score_1_inc;
  logic [SCORE_W-1:0] score_2_inc;

  always_comb begin
    score_1_inc = score_1_q + SCORE_W'(1);
    score_2_inc = score_2_q + SCORE_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      serve_cnt    <= '0;
      game_run_q   <= 1'b0;
      ball_reset_q <= 1'b0;
      serve_dir_q  <= 1'b0;
      score_1_q    <= '0;
      score_2_q    <= '0;
      winner_q     <= 2'b00;
    end else begin
      ball_reset_q <= 1'b0;
      case (state)
        S_IDLE, S_GAME_OVER: begin
          game_run_q <= 1'b0;
          if (start_pulse_q) begin
            score_1_q    <= '0;
            score_2_q    <= '0;
            winner_q     <= 2'b00;
            serve_dir_q  <= 1'b0;
            serve_cnt    <= '0;
            ball_reset_q <= 1'b1;
            state        <= S_SERVE;
          end
        end

        S_SERVE: begin
          if (serve_cnt == SERVE_LAST) begin
            game_run_q <= 1'b1;
            state      <= S_PLAY;
          end else begin
            serve_cnt <= serve_cnt + CNT_W'(1);
          end
        end

        S_PLAY: begin
          // Simultaneous goals cancel each other out. Play continues untouched.
          if (bus.goal_1 && !bus.goal_2) begin
            score_1_q   <= score_1_inc;
            serve_dir_q <= 1'b1;
            game_run_q  <= 1'b0;
            if (score_1_inc == WIN_VAL) begin
              winner_q <= 2'b01;
              state    <= S_GAME_OVER;
            end else begin
              serve_cnt    <= '0;
              ball_reset_q <= 1'b1;
              state        <= S_SERVE;
            end
          end else if (bus.goal_2 && !bus.goal_1) begin
            score_2_q   <= score_2_inc;
            serve_dir_q <= 1'b0;
            game_run_q  <= 1'b0;
            if (score_2_inc == WIN_VAL) begin
              winner_q <= 2'b10;
              state    <= S_GAME_OVER;
            end else begin
              serve_cnt    <= '0;
              ball_reset_q <= 1'b1;
              state        <= S_SERVE;
            end
          end
`ifdef MATCH_SEQUENCER_PAUSE_EN
          else if (pause_pulse_q) begin
            game_run_q <= 1'b0;
            state      <= S_PAUSED;
          end
`endif
        end

`ifdef MATCH_SEQUENCER_PAUSE_EN
        S_PAUSED: begin
          if (pause_pulse_q) begin
            game_run_q <= 1'b1;
            state      <= S_PLAY;
          end
        end
`endif

        default: begin
          game_run_q <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.game_run   = game_run_q;
  assign bus.ball_reset = ball_reset_q;
  assign bus.serve_dir  = serve_dir_q;
  assign bus.score_1    = score_1_q;
  assign bus.score_2    = score_2_q;
  assign bus.winner     = winner_q;

endmodule
